// File: rtl/des_ks_pkg.sv
// des_ks_pkg: shared types, tables and helpers for the DES key schedule
// Contents: state enum, round-index width, per-round shift schedule,
// PC1 selection table, PC1 and 28-bit rotate helpers.
// Bit order: DES bit n lives at vector index (width - n).
package des_ks_pkg;

    localparam int ROUND_IDX_W = 4;

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    // Entry k is the left-shift amount of DES round k+1
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        return (n == 2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
        return (n == 2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_key_sched_pc2.sv
// des_pc2_compress: combinational DES PC2 compression of the 56-bit C/D value
// Ports: cd  (in, 56)  concatenated C/D halves, C in the upper 28 bits
//        key (out, 48) compressed round key
module des_pc2_compress (
    input  logic [55:0] cd,
    output logic [47:0] key
);

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES bits 9,18,22,25,35,38,43,54 are discarded by PC2
    logic dropped_unused;
    assign dropped_unused = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

    always_comb begin
        key = '0;
        for (int i = 0; i < 48; i++) key[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    end

endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: streams the 16 DES round keys, forward (encrypt) or reverse (decrypt)
// Ports: clk, rst (async, active high)
//        key_in[63:0], decrypt, start, abort  - run request, sampled on accepted start
//        round_key[47:0], round_idx[3:0], key_valid / key_ready - round key stream
//        busy, done (one-cycle pulse after the final handshake)
//        parity_err - only when DES_KS_PARITY_CHK_EN is defined: odd-parity key check
module des_key_sched
    import des_ks_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            key_in,
    input  logic                   decrypt,
    input  logic                   start,
    input  logic                   abort,
    output logic [47:0]            round_key,
    output logic                   key_valid,
    input  logic                   key_ready,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   busy,
`ifdef DES_KS_PARITY_CHK_EN
    output logic                   parity_err,
`endif
    output logic                   done
);

    localparam logic [ROUND_IDX_W-1:0] LAST  = ROUND_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_IDX_W-1:0] FIRST = '0;

    state_t                 state_q, state_d;
    logic [55:0]            cd_q, cd_d;
    logic [ROUND_IDX_W-1:0] idx_q, idx_d;
    logic                   dec_q, dec_d;

    logic [55:0]            cd_key, cd_key_rot, cd_step;
    logic [ROUND_IDX_W-1:0] idx_inc;
    logic                   load, hs, final_key, par_bad;

    assign cd_key     = pc1(key_in);
    assign cd_key_rot = {rotl(cd_key[55:28], 1), rotl(cd_key[27:0], 1)};
    assign idx_inc    = idx_q + 1'b1;
    // Decrypt undoes the shift of the round just emitted; encrypt applies the next round's shift
    assign cd_step    = dec_q ? {rotr(cd_q[55:28], SHIFTS[idx_q]), rotr(cd_q[27:0], SHIFTS[idx_q])}
                              : {rotl(cd_q[55:28], SHIFTS[idx_inc]), rotl(cd_q[27:0], SHIFTS[idx_inc])};
    assign final_key  = idx_q == (dec_q ? FIRST : LAST);
    assign load       = state_q == IDLE && start;
    assign hs         = state_q == GEN && key_ready;

`ifdef DES_KS_PARITY_CHK_EN
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < 8; i++) par_bad |= ~^key_in[8*i +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err <= 1'b0;
        else if (load && !abort)
            parity_err <= par_bad;
    end
`else
    logic parity_unused;
    assign par_bad       = 1'b0;
    assign parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8], key_in[0]};
`endif

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        if (abort)
            state_d = IDLE;
        else if (load) begin
            state_d = par_bad ? DONE : GEN;
            cd_d    = decrypt ? cd_key : cd_key_rot;
            idx_d   = decrypt ? LAST : FIRST;
            dec_d   = decrypt;
        end else if (hs) begin
            state_d = final_key ? DONE : GEN;
            cd_d    = final_key ? cd_q : cd_step;
            idx_d   = final_key ? idx_q : (dec_q ? idx_q - 1'b1 : idx_inc);
        end else if (state_q == DONE)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
        end
    end

    des_pc2_compress u_pc2 (
        .cd  (cd_q),
        .key (round_key)
    );

    assign key_valid = state_q == GEN;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: scoreboard bench for des_key_sched
// Expected round keys come from an independent cumulative-shift DES key schedule
// model, queued when a run starts and consumed on each key handshake.
// Define DES_KS_PARITY_CHK_EN to also exercise the parity-check build.
module tb_des_key_sched;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] BKEY = 64'h123457799BBCDFF1;
    localparam logic [47:0] K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

    localparam int SH_R [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC1_R [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_R [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef struct {
        logic [3:0]  idx;
        logic [47:0] key;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, decrypt, start, abort, key_ready;
    logic [63:0] key_in;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        key_valid, busy, done;
`ifdef DES_KS_PARITY_CHK_EN
    logic        parity_err;
`endif

    exp_t        q[$];
    exp_t        e;
    int          total = 0, bad = 0;
    int          cyc = 0, hs_cnt = 0, done_cnt = 0, kv_cnt = 0, last_hs_cyc = -1;
    logic [47:0] first_key, last_key;

    des_key_sched dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .decrypt    (decrypt),
        .start      (start),
        .abort      (abort),
        .round_key  (round_key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .round_idx  (round_idx),
        .busy       (busy),
`ifdef DES_KS_PARITY_CHK_EN
        .parity_err (parity_err),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] o;
        int          tot;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1_R[i]];
            d[27-i] = k[64-PC1_R[i+28]];
        end
        tot = 0;
        for (int i = 0; i < r; i++) tot += SH_R[i];
        for (int i = 0; i < tot; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_R[i]];
        return o;
    endfunction

    task automatic push_exp(input logic [63:0] k, input logic dec);
        exp_t x;
        for (int r = 1; r <= 16; r++) begin
            x.idx = dec ? 4'(16 - r) : 4'(r - 1);
            x.key = ref_key(k, dec ? 17 - r : r);
            q.push_back(x);
        end
    endtask

    // Monitor: compares every valid key against the scoreboard head, pops on handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                if (last_hs_cyc >= 0) check("done_lat", 64'(cyc - last_hs_cyc), 1);
                last_hs_cyc = -1;
            end
            if (key_valid) begin
                kv_cnt++;
                if (q.size() == 0)
                    check("unexp_valid", key_valid, 0);
                else if (!abort) begin
                    e = q[0];
                    if (key_ready) begin
                        check("hs_key", round_key, e.key);
                        check("hs_idx", round_idx, e.idx);
                        void'(q.pop_front());
                        hs_cnt++;
                        if (hs_cnt == 1) first_key = round_key;
                        if (q.size() == 0) begin
                            last_key    = round_key;
                            last_hs_cyc = cyc;
                        end
                    end else begin
                        check("stall_key", round_key, e.key);
                        check("stall_idx", round_idx, e.idx);
                    end
                end
            end
        end
    end

    task automatic kick(input logic [63:0] k, input logic dec);
        hs_cnt  = 0;
        push_exp(k, dec);
        key_in    = k;
        decrypt   = dec;
        start     = 1'b1;
        key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [63:0] k, input logic dec, input bit bp, input bit poke);
        int d0, t;
        d0 = done_cnt;
        kick(k, dec);
        check("lat_valid", key_valid, 1);
        check("lat_busy", busy, 1);
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            key_ready = bp ? ($urandom_range(2) != 0) : 1'b1;
            start     = poke && busy;
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        check("run_timeout", 64'(t < 200), 1);
        @(posedge clk); #1;
        check("end_busy", busy, 0);
        check("hs_count", 64'(hs_cnt), 16);
        check("done_count", 64'(done_cnt - d0), 1);
        check("q_left", 64'(q.size()), 0);
    endtask

    initial begin
        int d0, t, kv0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b0; decrypt = 1'b0; key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", round_idx, 0);
        check("rst_key", round_key, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(KEY, 1'b0, 1'b0, 1'b0);
        check("enc_first", first_key, K1);
        check("enc_last", last_key, K16);
        run(KEY, 1'b1, 1'b0, 1'b0);
        check("dec_first", first_key, K16);
        check("dec_last", last_key, K1);
        run(KEY, 1'b0, 1'b1, 1'b0);
        run(KEY, 1'b1, 1'b1, 1'b0);
        run(64'h0E329232EA6D0D73, 1'b0, 1'b1, 1'b0);

        // abort after the fifth handshake, with key_ready still high
        d0 = done_cnt;
        kick(KEY, 1'b0);
        t = 0;
        while (hs_cnt < 5 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_reach", 64'(hs_cnt), 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", key_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_hs", 64'(hs_cnt), 5);
        q.delete();
        last_hs_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_nodone", 64'(done_cnt - d0), 0);
        run(KEY, 1'b0, 1'b0, 1'b0);
        check("restart_k1", first_key, K1);

        // start pulsed throughout GEN and DONE must be ignored
        run(KEY, 1'b1, 1'b0, 1'b1);
        run(KEY, 1'b0, 1'b1, 1'b1);

        // asynchronous reset mid-run
        kick(KEY, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check("arst_valid", key_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_idx", round_idx, 0);
        check("arst_key", round_key, 0);
        q.delete();
        last_hs_cyc = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("arst_nodone", 64'(done_cnt - d0), 0);
        run(KEY, 1'b0, 1'b0, 1'b0);

`ifdef DES_KS_PARITY_CHK_EN
        d0  = done_cnt;
        kv0 = kv_cnt;
        key_in = BKEY; decrypt = 1'b0; start = 1'b1; key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("par_err", parity_err, 1);
        check("par_valid", key_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("par_done", 64'(done_cnt - d0), 1);
        check("par_kv", 64'(kv_cnt - kv0), 0);
        check("par_hold", parity_err, 1);
        run(KEY, 1'b0, 1'b0, 1'b0);
        check("par_clear", parity_err, 0);
        check("par_k1", first_key, K1);
`else
        kv0 = BKEY[31:0] == 32'h0 ? 1 : 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
